// File: rtl/cpu_mem_arbiter.sv
// Arbiter between the fetch and load/store ports and a single memory port, one outstanding transaction at a time.
// Define ARB_RR_EN to replace fixed data-over-inst priority with round-robin selection.
module cpu_mem_arbiter (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t state, next_state;
   logic   owner_data;
   logic   owner_wr;
   logic   sel_data;
   logic   take;

`ifdef ARB_RR_EN
   // last_data remembers who won the most recent grant so a tie goes to the other master
   logic last_data;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         last_data <= 1'b0;
      else if (take)
         last_data <= sel_data;
   end

   assign sel_data = data_req && (!inst_req || !last_data);
`else
   assign sel_data = data_req;
`endif

   assign take = (state == IDLE) && mem_req && mem_gnt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state   = state;
      mem_req      = 1'b0;
      mem_wr       = 1'b0;
      mem_wstrb    = 4'h0;
      mem_addr     = 32'h0;
      mem_wdata    = 32'h0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      case (state)
         IDLE: begin
            // Gated by resetn so nothing is requested while reset is held
            if (resetn && (inst_req || data_req)) begin
               mem_req = 1'b1;
               if (sel_data) begin
                  mem_wr    = data_wr;
                  mem_wstrb = data_wstrb;
                  mem_addr  = data_addr;
                  mem_wdata = data_wdata;
               end else begin
                  mem_addr  = inst_addr;
               end
               if (mem_gnt) begin
                  data_addr_ok = sel_data;
                  inst_addr_ok = !sel_data;
                  next_state   = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid)
               next_state = RESP;
         end
         RESP: begin
            inst_data_ok = !owner_data;
            data_data_ok = owner_data;
            next_state   = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Stores complete without touching data_rdata; only fetches and loads capture read data
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_data <= 1'b0;
         owner_wr   <= 1'b0;
         inst_rdata <= 32'h0;
         data_rdata <= 32'h0;
      end else begin
         if (take) begin
            owner_data <= sel_data;
            owner_wr   <= sel_data && data_wr;
         end
         if ((state == WAIT) && mem_rvalid) begin
            if (!owner_data)
               inst_rdata <= mem_rdata;
            else if (!owner_wr)
               data_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios, then random traffic against a transaction-level model.
// Define ARB_RR_EN for both the DUT and this bench to check the round-robin build.
module tb_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        mem_req, mem_wr, mem_gnt, mem_rvalid;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   cpu_mem_arbiter dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected)
         passCount++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
   endtask

   // Drives one cycle of inputs just after the rising edge, then waits for the falling edge to sample
   task automatic applyStimulus(input logic ireq, input logic dreq, input logic gnt,
                                input logic rvalid, input logic [31:0] rdata);
      @(posedge clk);
      #1;
      inst_req   = ireq;
      data_req   = dreq;
      mem_gnt    = gnt;
      mem_rvalid = rvalid;
      mem_rdata  = rdata;
      @(negedge clk);
   endtask

   task automatic doReset();
      resetn     = 1'b0;
      inst_req   = 1'b0;
      data_req   = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   logic [31:0] mem_model [logic [31:0]];

   function automatic logic [31:0] memRead(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_A5A5);
   endfunction

   // Random-phase model state: phase 0 = arbiter free, 1 = awaiting memory response, 2 = response being returned
   bit          i_act, i_busy, d_act, d_busy, d_w, own_d, own_w, last_d, sel_d, exp_req, acc, rv;
   logic [31:0] i_a, d_a, d_wd, resp_val, exp_ird, exp_drd, wv;
   logic [3:0]  d_s;
   int          phase, wcnt;

   initial begin
      resetn     = 1'b0;
      inst_req   = 1'b1;
      data_req   = 1'b1;
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      inst_addr  = 32'h1C00_0000;
      data_addr  = 32'h0000_1000;
      data_wr    = 1'b0;
      data_wstrb = 4'h0;
      data_wdata = 32'h0;
      repeat (2) @(negedge clk);
      checkOutput("rst_mem_req", 32'(mem_req), 0);
      checkOutput("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
      checkOutput("rst_data_addr_ok", 32'(data_addr_ok), 0);
      checkOutput("rst_inst_data_ok", 32'(inst_data_ok), 0);
      checkOutput("rst_data_data_ok", 32'(data_data_ok), 0);
      checkOutput("rst_inst_rdata", inst_rdata, 0);
      checkOutput("rst_data_rdata", data_rdata, 0);
      inst_req = 1'b0;
      data_req = 1'b0;
      mem_gnt  = 1'b0;
      resetn   = 1'b1;

      // Single fetch with an immediate grant and a response two cycles later
      applyStimulus(1, 0, 1, 0, 32'h0);
      checkOutput("f_mem_req", 32'(mem_req), 1);
      checkOutput("f_mem_addr", mem_addr, 32'h1C00_0000);
      checkOutput("f_mem_wr", 32'(mem_wr), 0);
      checkOutput("f_mem_wstrb", 32'(mem_wstrb), 0);
      checkOutput("f_addr_ok", 32'(inst_addr_ok), 1);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("f_wait_mem_req", 32'(mem_req), 0);
      applyStimulus(0, 0, 0, 1, 32'h0280_0C0C);
      checkOutput("f_early_data_ok", 32'(inst_data_ok), 0);
      applyStimulus(0, 0, 0, 0, 32'hFFFF_FFFF);
      checkOutput("f_data_ok", 32'(inst_data_ok), 1);
      checkOutput("f_rdata", inst_rdata, 32'h0280_0C0C);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("f_data_ok_drop", 32'(inst_data_ok), 0);
      checkOutput("f_rdata_hold", inst_rdata, 32'h0280_0C0C);

      // Collision: the load wins, the fetch waits until the arbiter is idle again
      inst_addr = 32'h1C00_0004;
      applyStimulus(1, 1, 1, 0, 32'h0);
      checkOutput("c_data_addr_ok", 32'(data_addr_ok), 1);
      checkOutput("c_inst_addr_ok", 32'(inst_addr_ok), 0);
      checkOutput("c_mem_addr", mem_addr, 32'h0000_1000);
      applyStimulus(1, 0, 1, 0, 32'h0);
      checkOutput("c_wait_mem_req", 32'(mem_req), 0);
      checkOutput("c_wait_inst_ok", 32'(inst_addr_ok), 0);
      applyStimulus(1, 0, 1, 1, 32'hCAFE_F00D);
      checkOutput("c_rv_inst_ok", 32'(inst_addr_ok), 0);
      applyStimulus(1, 0, 1, 0, 32'h0);
      checkOutput("c_data_data_ok", 32'(data_data_ok), 1);
      checkOutput("c_data_rdata", data_rdata, 32'hCAFE_F00D);
      checkOutput("c_resp_inst_ok", 32'(inst_addr_ok), 0);
      applyStimulus(1, 0, 1, 0, 32'h0);
      checkOutput("c_inst_addr_ok2", 32'(inst_addr_ok), 1);
      checkOutput("c_mem_addr2", mem_addr, 32'h1C00_0004);
      applyStimulus(0, 0, 0, 1, 32'h1111_2222);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("c_inst_data_ok", 32'(inst_data_ok), 1);
      checkOutput("c_inst_rdata", inst_rdata, 32'h1111_2222);
      checkOutput("c_no_data_ok", 32'(data_data_ok), 0);

      // Store under three cycles of back-pressure
      data_wr    = 1'b1;
      data_wstrb = 4'h3;
      data_wdata = 32'hDEAD_BEEF;
      data_addr  = 32'h0000_2000;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 0, 0, 32'h0);
         checkOutput("bp_mem_req", 32'(mem_req), 1);
         checkOutput("bp_mem_addr", mem_addr, 32'h0000_2000);
         checkOutput("bp_mem_wstrb", 32'(mem_wstrb), 32'h3);
         checkOutput("bp_addr_ok", 32'(data_addr_ok), 0);
      end
      applyStimulus(0, 1, 1, 0, 32'h0);
      checkOutput("s_addr_ok", 32'(data_addr_ok), 1);
      checkOutput("s_mem_wr", 32'(mem_wr), 1);
      checkOutput("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 0, 1, 32'h1234_5678);
      checkOutput("s_early_ok", 32'(data_data_ok), 0);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("s_data_ok", 32'(data_data_ok), 1);
      checkOutput("s_rdata_kept", data_rdata, 32'hCAFE_F00D);
      applyStimulus(0, 0, 0, 1, 32'h5555_5555);
      checkOutput("idle_rv_ignored", inst_rdata, 32'h1111_2222);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("idle_rv_no_ok", 32'(inst_data_ok | data_data_ok), 0);
      checkOutput("idle_rv_rdata", inst_rdata, 32'h1111_2222);

      // Reset while a fetch waits for memory: the late response must be dropped
      data_wr = 1'b0;
      applyStimulus(1, 0, 1, 0, 32'h0);
      checkOutput("rw_addr_ok", 32'(inst_addr_ok), 1);
      applyStimulus(0, 0, 0, 0, 32'h0);
      #1 resetn = 1'b0;
      #1;
      checkOutput("rw_rst_rdata", inst_rdata, 0);
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(0, 0, 0, 1, 32'h7777_7777);
      applyStimulus(0, 0, 0, 0, 32'h0);
      checkOutput("rw_no_data_ok", 32'(inst_data_ok), 0);
      checkOutput("rw_rdata", inst_rdata, 0);
      applyStimulus(1, 0, 0, 0, 32'h0);
      checkOutput("rw_idle_req", 32'(mem_req), 1);
      checkOutput("rw_idle_no_ok", 32'(inst_addr_ok), 0);

      // Both masters requesting continuously for four transactions
      doReset();
      for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
         sel_d = (t % 2 == 0);
`else
         sel_d = 1'b1;
`endif
         applyStimulus(1, 1, 1, 0, 32'h0);
         checkOutput("both_data_ok_grant", 32'(data_addr_ok), 32'(sel_d));
         checkOutput("both_inst_ok_grant", 32'(inst_addr_ok), 32'(!sel_d));
         applyStimulus(1, 1, 1, 1, $urandom);
         checkOutput("both_wait_ok", 32'(inst_addr_ok | data_addr_ok), 0);
         applyStimulus(1, 1, 1, 0, 32'h0);
         checkOutput("both_resp_data_ok", 32'(data_data_ok), 32'(sel_d));
         checkOutput("both_resp_inst_ok", 32'(inst_data_ok), 32'(!sel_d));
      end

      // Random traffic: masters issue and hold requests, the memory grants and answers at random
      doReset();
      i_act = 0; i_busy = 0; d_act = 0; d_busy = 0;
      phase = 0; wcnt = 0; last_d = 0; own_d = 0; own_w = 0;
      exp_ird = 0; exp_drd = 0; resp_val = 0;
      i_a = 32'h1C00_0000; d_a = 32'h0000_1000; d_w = 0; d_s = 0; d_wd = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(posedge clk);
         #1;
         if (!i_act && !i_busy && $urandom_range(0, 1) == 1) begin
            i_act = 1;
            i_a   = 32'h1C00_0000 | 32'($urandom_range(0, 15) << 2);
         end
         if (!d_act && !d_busy && $urandom_range(0, 1) == 1) begin
            d_act = 1;
            d_w   = 1'($urandom_range(0, 1));
            d_a   = 32'h0000_1000 | 32'($urandom_range(0, 15) << 2);
            d_s   = d_w ? 4'($urandom_range(1, 15)) : 4'h0;
            d_wd  = $urandom;
         end
         inst_req   = i_act;
         inst_addr  = i_a;
         data_req   = d_act;
         data_wr    = d_w;
         data_addr  = d_a;
         data_wstrb = d_s;
         data_wdata = d_wd;
         mem_gnt    = ($urandom_range(0, 3) != 0);
         rv         = (phase == 1) ? (wcnt == 0) : ($urandom_range(0, 7) == 0);
         mem_rvalid = rv;
         mem_rdata  = (phase == 1 && rv) ? resp_val : $urandom;
         @(negedge clk);

`ifdef ARB_RR_EN
         sel_d = d_act && (!i_act || !last_d);
`else
         sel_d = d_act;
`endif
         exp_req = (phase == 0) && (i_act || d_act);
         acc     = exp_req && mem_gnt;
         checkOutput("r_mem_req", 32'(mem_req), 32'(exp_req));
         if (exp_req) begin
            checkOutput("r_mem_addr", mem_addr, sel_d ? d_a : i_a);
            checkOutput("r_mem_wr", 32'(mem_wr), 32'(sel_d && d_w));
            checkOutput("r_mem_wstrb", 32'(mem_wstrb), sel_d ? 32'(d_s) : 0);
            if (sel_d && d_w)
               checkOutput("r_mem_wdata", mem_wdata, d_wd);
         end
         checkOutput("r_inst_addr_ok", 32'(inst_addr_ok), 32'(acc && !sel_d));
         checkOutput("r_data_addr_ok", 32'(data_addr_ok), 32'(acc && sel_d));
         checkOutput("r_inst_data_ok", 32'(inst_data_ok), 32'(phase == 2 && !own_d));
         checkOutput("r_data_data_ok", 32'(data_data_ok), 32'(phase == 2 && own_d));
         checkOutput("r_inst_rdata", inst_rdata, exp_ird);
         checkOutput("r_data_rdata", data_rdata, exp_drd);

         if (phase == 2) begin
            phase = 0;
            if (own_d) d_busy = 0;
            else       i_busy = 0;
         end else if (phase == 1) begin
            if (rv) begin
               phase = 2;
               if (!own_d)     exp_ird = resp_val;
               else if (!own_w) exp_drd = resp_val;
            end else begin
               wcnt--;
            end
         end else if (acc) begin
            phase  = 1;
            own_d  = sel_d;
            own_w  = sel_d && d_w;
            last_d = sel_d;
            wcnt   = $urandom_range(0, 3);
            if (sel_d) begin
               d_act  = 0;
               d_busy = 1;
               if (d_w) begin
                  wv = memRead(d_a);
                  for (int b = 0; b < 4; b++)
                     if (d_s[b]) wv[8*b +: 8] = d_wd[8*b +: 8];
                  mem_model[d_a] = wv;
                  resp_val = $urandom;
               end else begin
                  resp_val = memRead(d_a);
               end
            end else begin
               i_act    = 0;
               i_busy   = 1;
               resp_val = memRead(i_a);
            end
         end
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
Parameters: none; all widths fixed at 32-bit address/data, 4-bit strobe.
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port inst_req  in  1  fetch read request, held until inst_addr_ok.
REQ-004 SHALL have port inst_addr  in  32  fetch address.
REQ-005 SHALL have port inst_addr_ok  out  1  fetch request accepted (1-cycle pulse).
REQ-006 SHALL have port inst_data_ok  out  1  fetch data valid (1-cycle pulse).
REQ-007 SHALL have port inst_rdata  out  32  fetch data, valid with inst_data_ok.
REQ-008 SHALL have port data_req  in  1  load/store request, held until data_addr_ok.
REQ-009 SHALL have port data_wr  in  1  1 = store, 0 = load.
REQ-010 SHALL have port data_wstrb  in  4  store byte enables.
REQ-011 SHALL have port data_addr  in  32  load/store address.
REQ-012 SHALL have port data_wdata  in  32  store data.
REQ-013 SHALL have port data_addr_ok  out  1  load/store accepted (1-cycle pulse).
REQ-014 SHALL have port data_data_ok  out  1  load data valid or store complete (1-cycle pulse).
REQ-015 SHALL have port data_rdata  out  32  load data, valid with data_data_ok.
REQ-016 SHALL have port mem_req  out  1  request to memory.
REQ-017 SHALL have ports mem_wr out 1, mem_wstrb out 4, mem_addr out 32, mem_wdata out 32: request attributes, valid while mem_req.
REQ-018 SHALL have port mem_gnt  in  1  memory accepts request this cycle when mem_req=1.
REQ-019 SHALL have port mem_rvalid  in  1  response for the outstanding request (reads and writes).
REQ-020 SHALL have port mem_rdata  in  32  read data, valid with mem_rvalid.

Function
REQ-021 SHALL implement FSM IDLE, WAIT, RESP; exactly one memory transaction outstanding at any time.
REQ-022 In IDLE, SHALL drive mem_req=1 combinationally when inst_req or data_req is 1; mem_* attributes come from the selected master; for inst, mem_wr=0 and mem_wstrb=0.
REQ-023 Selection SHALL give data priority over inst when both request in the same cycle (default build).
REQ-024 In IDLE, mem_req=1 with mem_gnt=1 SHALL pulse the selected master's addr_ok in the same cycle, latch owner, and move to WAIT.
REQ-025 In IDLE with mem_gnt=0, SHALL stay in IDLE with no addr_ok; selection re-evaluates every cycle.
REQ-026 In WAIT, mem_req SHALL be 0; addr_ok to both masters SHALL be 0; mem_rvalid=1 SHALL capture mem_rdata into the owner's rdata register and move to RESP.
REQ-027 In RESP, SHALL pulse the owner's data_ok for exactly one cycle, then return to IDLE; latency is mem_rvalid -> data_ok = 1 cycle.
REQ-028 inst_rdata/data_rdata SHALL hold their last captured value until the next capture for that master.
REQ-029 mem_rvalid outside WAIT SHALL be ignored.
REQ-030 A request arriving in WAIT/RESP SHALL be stalled (no addr_ok) until IDLE.

Reset
REQ-031 resetn=0 SHALL immediately force IDLE, mem_req=0, all addr_ok/data_ok=0, inst_rdata=data_rdata=0, owner=inst, RR pointer=inst.
REQ-032 Reset mid-transaction SHALL drop the outstanding response; no data_ok is issued after release.

Configuration
REQ-033 With macro ARB_RR_EN defined, selection in REQ-023 SHALL become round-robin: on simultaneous requests, grant the master not granted last; the pointer updates only on mem_gnt.
REQ-034 Without ARB_RR_EN, fixed data-over-inst priority SHALL apply and no pointer register shall exist.

Verification
REQ-035 Single fetch: inst_req, addr 0x1C000000, mem_gnt=1 at once, mem_rvalid 2 cycles later with 0x02800C0C -> inst_addr_ok same cycle, inst_data_ok 1 cycle after rvalid, inst_rdata=0x02800C0C.
REQ-036 Collision: inst_req and data_req (load 0x00001000) together, default build -> data granted first, inst_addr_ok only after data_data_ok and the return to IDLE.
REQ-037 Store: data_wr=1, wstrb=0x3, wdata=0xDEADBEEF -> mem_wr=1, mem_wstrb=0x3, data_data_ok after mem_rvalid, data_rdata unchanged.
REQ-038 Back-pressure: mem_gnt=0 for 3 cycles -> mem_req stays 1, attributes stable, no addr_ok until the cycle mem_gnt=1.
REQ-039 ARB_RR_EN: both masters request continuously for 4 transactions -> grants alternate data, inst, data, inst.
REQ-040 Reset during WAIT: resetn=0 then mem_rvalid=1 after release -> no data_ok pulse, FSM in IDLE.
